// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer and its dwell timer.
package scan_pkg;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam int SEL_W_DEFAULT = 3;
  localparam int SEL_MIN       = 0;
  localparam int SEL_MAX       = (1 << SEL_W_DEFAULT) - 1;

  // True when the requested endpoint (first or last code) is the all-ones code.
  function automatic logic end_is_max(input logic dir_down, input logic is_last);
    return dir_down ^ is_last;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that sets how long each select code is held; expire flags a zero count.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  // Counting stops at zero, so the full dwell range needs no overflow handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a select code through its full range, up or down, holding each code
// for dwell+1 cycles, in continuous or single-pass mode.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEFAULT,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic               dir_down,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  state_t             state;
  logic               oneshot_q;
  logic               dir_q;
  logic [DWELL_W-1:0] dwell_q;

  logic               expire;
  logic               load;
  logic [DWELL_W-1:0] load_val;
  logic               accept;
  logic               at_last;
  logic [SEL_W-1:0]   start_first;
  logic [SEL_W-1:0]   run_first;
  logic [SEL_W-1:0]   run_last;

  // Endpoints for a new scan come from the live inputs; endpoints during a run come from the latched copies.
  always_comb begin
    start_first = end_is_max(dir_down, 1'b0) ? '1 : SEL_W'(SEL_MIN);
    run_first   = end_is_max(dir_q, 1'b0)    ? '1 : SEL_W'(SEL_MIN);
    run_last    = end_is_max(dir_q, 1'b1)    ? '1 : SEL_W'(SEL_MIN);
    accept      = (state == IDLE) && start && !stop;
    at_last     = (sel == run_last);
    load        = accept ||
                  ((state == RUN) && !stop && expire && !(at_last && oneshot_q));
    load_val    = accept ? dwell : dwell_q;
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      oneshot_q <= 1'b0;
      dir_q     <= 1'b0;
      dwell_q   <= '0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            sel       <= start_first;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            oneshot_q <= oneshot;
            dir_q     <= dir_down;
            dwell_q   <= dwell;
          end
        end
        RUN: begin
          // Stop outranks expiry, so an abort at the last code never pulses done or wrap.
          if (stop) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (expire) begin
            if (!at_last) begin
              sel <= dir_q ? sel - 1'b1 : sel + 1'b1;
            end else if (!oneshot_q) begin
              sel  <= run_first;
              wrap <= 1'b1;
            end else begin
              state     <= IDLE;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: a position-based reference model predicts every cycle's
// outputs, and a monitor compares them shortly after each rising edge.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       oneshot = 1'b0;
  logic       dir_down = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       wrap;
  logic       done;

  typedef struct packed {
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic       wrap;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position within the run counted in cycles since the start edge.
  logic m_run = 1'b0;
  logic m_one = 1'b0;
  logic m_dir = 1'b0;
  int   m_len = 1;
  int   m_step = 0;
  int   m_sel = 0;

  scan_sequencer #(
    .SEL_W   (3),
    .DWELL_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .dir_down  (dir_down),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_field(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("sel", int'(sel), int'(e.sel));
    check_field("sel_valid", int'(sel_valid), int'(e.valid));
    check_field("busy", int'(busy), int'(e.busy));
    check_field("wrap", int'(wrap), int'(e.wrap));
    check_field("done", int'(done), int'(e.done));
    check_field("wrap_done_exclusive", int'(wrap & done), 0);
  endtask

  task automatic model_step(input logic st, input logic sp, input logic os,
                            input logic dd, input logic [7:0] dw, output exp_t e);
    int pos;
    e = '0;
    if (!m_run) begin
      if (st && !sp) begin
        m_run  = 1'b1;
        m_step = 0;
        m_one  = os;
        m_dir  = dd;
        m_len  = int'(dw) + 1;
        m_sel  = dd ? 7 : 0;
      end
    end else if (sp) begin
      m_run = 1'b0;
    end else begin
      m_step++;
      if (m_one && m_step == 8 * m_len) begin
        m_run  = 1'b0;
        e.done = 1'b1;
      end else begin
        pos    = (m_step / m_len) % 8;
        m_sel  = m_dir ? 7 - pos : pos;
        e.wrap = !m_one && (m_step % (8 * m_len) == 0);
      end
    end
    e.sel   = 3'(m_sel);
    e.valid = m_run;
    e.busy  = m_run;
  endtask

  // Drive one cycle's inputs after the falling edge and queue the prediction for the next rising edge.
  task automatic apply_stimulus(input logic st, input logic sp, input logic os,
                                input logic dd, input logic [7:0] dw);
    exp_t e;
    @(negedge clk);
    start    = st;
    stop     = sp;
    oneshot  = os;
    dir_down = dd;
    dwell    = dw;
    model_step(st, sp, os, dd, dw, e);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_step = 0;
    m_sel  = 0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n && exp_q.size() > 0) begin
      check_output(exp_q.pop_front());
    end
  end

  initial begin
    int guard;
    $display("[TB] scan_sequencer bench starting");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle_cycles(5);

    // Continuous up, dwell 0: wraps back to 0 on the ninth edge.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle_cycles(11);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle_cycles(2);

    // Oneshot down, dwell 2: done on the 24th edge, sel parked at 0.
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    idle_cycles(26);

    // Continuous up, dwell 1, stopped while sel is 3, then restarted.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    guard = 0;
    while (m_sel != 3 && guard < 50) begin
      idle_cycles(1);
      guard++;
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    idle_cycles(3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    idle_cycles(2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    idle_cycles(3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    // Long dwell oneshot pass exercising the widest counter value.
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
    idle_cycles(8 * 256 + 2);

    // Randomized scans with mid-run input noise, stray starts and occasional stops.
    for (int s = 0; s < 25; s++) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
                     8'($urandom_range(0, 3)));
      for (int c = 0; c < int'($urandom_range(10, 80)); c++) begin
        apply_stimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
                       1'($urandom), 1'($urandom), 8'($urandom));
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    // Asynchronous reset in the middle of a continuous scan at sel 5.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    guard = 0;
    while (m_sel != 5 && guard < 50) begin
      run_cycles(1);
      guard++;
    end
    @(posedge clk);
    #3;
    check_field("pre_reset_sel", int'(sel), 5);
    rst_n = 1'b0;
    #1;
    check_field("async_sel", int'(sel), 0);
    check_field("async_sel_valid", int'(sel_valid), 0);
    check_field("async_busy", int'(busy), 0);
    check_field("async_wrap", int'(wrap), 0);
    check_field("async_done", int'(done), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(4);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    idle_cycles(10);

    @(posedge clk);
    #3;
    check_field("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream code generator for the 3-to-8 decoder.
- Steps a 3-bit select code through all 8 values, up or down, holding each code for a programmable number of cycles.
- Runs either continuously with wrap-around or as a single pass.
- Its `sel` output drives the decoder's `w` input directly; `sel_valid` qualifies it for downstream enable logic.

Parameters:
- SEL_W, 3, width of the select code; the sequence covers 0 .. 2^SEL_W-1.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a scan; honoured only in IDLE.
- stop  input  1  abort request; honoured in any state.
- oneshot  input  1  1 = single pass then stop; 0 = continuous wrap. Sampled only when start is accepted.
- dir_down  input  1  1 = count 7→0; 0 = count 0→7. Sampled only when start is accepted.
- dwell  input  DWELL_W  each code is held for dwell+1 cycles. Sampled only when start is accepted.
- sel  output  SEL_W  current select code, registered.
- sel_valid  output  1  sel is an active scan value.
- busy  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse when the sequence restarts in continuous mode.
- done  output  1  one-cycle pulse at the end of a oneshot pass.

Behaviour:
- Reset: all outputs are registered. While rst_n=0: sel=0, sel_valid=0, busy=0, wrap=0, done=0, state=IDLE, dwell counter=0.
- States:
  - IDLE: sel holds its last value, sel_valid=0.
  - RUN: scanning.
- IDLE→RUN: start=1 and stop=0 at a rising edge. On that edge:
  - sel ← FIRST (0 if dir_down=0, else 7).
  - sel_valid ← 1, busy ← 1.
  - Counter ← captured dwell.
  - oneshot, dir_down and dwell are latched into internal registers.
- RUN, counter ≠ 0: counter decrements each cycle; sel unchanged.
- RUN, counter = 0 and sel ≠ LAST (7 up, 0 down): sel steps ±1, counter reloads from the latched dwell. Each code is therefore visible for exactly dwell+1 cycles.
- RUN, counter = 0 and sel = LAST, latched oneshot=0:
  - sel ← FIRST, counter reloads, wrap=1 for exactly that cycle.
  - There is no gap cycle; the wrap pulse coincides with the first cycle sel shows FIRST again.
- RUN, counter = 0 and sel = LAST, latched oneshot=1:
  - state ← IDLE, sel_valid ← 0, busy ← 0, done=1 for one cycle.
  - sel keeps LAST.
- Stop:
  - stop=1 in RUN: next edge goes to IDLE with sel_valid=0, busy=0. No done pulse, no wrap pulse, sel frozen at its current value.
  - stop wins over every other event at the same edge, including expiry at LAST.
- start and stop together in IDLE: stay in IDLE.
- start while in RUN: ignored, no restart.
- Input changes mid-run: changes to dwell, oneshot or dir_down during RUN have no effect until the next accepted start.
- Full-pass length: a oneshot pass takes 8*(dwell+1) cycles from the start edge to the done edge. dwell=0 advances every cycle.
- Counter width: counter is DWELL_W bits. dwell=2^DWELL_W-1 is legal; there is no overflow because the counter only decrements.
- Reset mid-operation: immediately forces the reset values above; any in-flight pulse is cleared.
- wrap and done are mutually exclusive and never both high.

Decomposition:
- Shared package `scan_pkg`:
  - State enum {IDLE, RUN}.
  - SEL_W default.
  - Constants SEL_MIN=0 and SEL_MAX=2^SEL_W-1.
  - Function for FIRST/LAST selection from dir.
- One natural sub-module, `dwell_timer`: DWELL_W down-counter with `load`, `load_val` and an `expire` output (counter==0). `scan_sequencer` owns the FSM and the sel datapath.

Test Plan:
- Reset, then hold start=0 for 5 cycles → sel=0, sel_valid=0, busy=0, wrap=0, done=0 throughout.
- start with dwell=0, oneshot=0, dir_down=0 → sel shows 0,1,2,…,7,0,1 on consecutive cycles; wrap=1 only in the cycle sel returns to 0 (9th cycle after start); busy stays 1.
- start with dwell=2, oneshot=1, dir_down=1 → sel=7 for 3 cycles, then 6 for 3 cycles, …, 0 for 3 cycles; done=1 at the 24th edge after start; then busy=0, sel_valid=0, sel stays 0.
- Continuous up, dwell=1; assert stop while sel=3 → next cycle busy=0 and sel_valid=0, sel frozen at 3, no done or wrap; a later start restarts from sel=0.
- Edge cases:
  - start and stop together in IDLE → remains IDLE.
  - start during RUN → sequence unaffected.
  - Change dwell from 1 to 5 mid-run → hold time stays 2 cycles per code.
- Assert rst_n=0 mid-run at sel=5 → outputs go to reset values asynchronously, before the next clock edge; after release, IDLE awaits start.
